// File: rtl/regfile_wb_if.sv
// Write-side bus of the register file: ALU and memory result producers plus the
// registered single write port.
// Handshake: a result transfers on the posedge where valid && ready are both high;
// while valid is high and ready is low, the producer holds addr/data stable.
interface regfile_wb_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          regwrite;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, regwrite, wr_addr, wr_data
  );

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, regwrite, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU results (direct) and buffered memory results onto the register file's
// single registered write port, exposing a mask of registers with buffered writes.
module regfile_wb_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  regfile_wb_if.slave              bus,
  output logic [2**AW-1:0]         pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [AW-1:0]    addrMem [DEPTH];
  logic [DW-1:0]    dataMem [DEPTH];
  logic [DEPTH-1:0] entryVld;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;

  logic aluFire;
  logic memFire;
  logic popHead;

  // A buffered write to the ALU's target is older, so the ALU waits behind it.
  assign bus.alu_ready = !pend_mask[bus.alu_addr];
  assign bus.mem_ready = (fifo_count < FullCnt) && !flush;

  assign aluFire = bus.alu_valid && bus.alu_ready;
  assign memFire = bus.mem_valid && bus.mem_ready;
  assign popHead = !aluFire && (fifo_count != '0) && !flush;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryVld[i]) pend_mask[addrMem[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
      entryVld   <= '0;
    end else if (flush) begin
      rdPtr      <= '0;
      wrPtr      <= '0;
      fifo_count <= '0;
      entryVld   <= '0;
    end else begin
      // Push and pop never share a slot: a pop needs count>0, a push needs count<DEPTH.
      if (memFire) begin
        entryVld[wrPtr] <= 1'b1;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (popHead) begin
        entryVld[rdPtr] <= 1'b0;
        rdPtr           <= rdPtr + 1'b1;
      end
      case ({memFire, popHead})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (memFire) begin
      addrMem[wrPtr] <= bus.mem_addr;
      dataMem[wrPtr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.regwrite <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
    end else if (aluFire) begin
      bus.regwrite <= 1'b1;
      bus.wr_addr  <= bus.alu_addr;
      bus.wr_data  <= bus.alu_data;
    end else if (popHead) begin
      bus.regwrite <= 1'b1;
      bus.wr_addr  <= addrMem[rdPtr];
      bus.wr_data  <= dataMem[rdPtr];
    end else begin
      bus.regwrite <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by random traffic, all
// checked against a queue-based model of the write-back rules.
module tb_regfile_wb_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [2**AW-1:0]     pendMask;
  logic [$clog2(DEPTH):0] fifoCount;

  regfile_wb_if #(.DW(DW), .AW(AW)) bus ();

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .pend_mask  (pendMask),
    .fifo_count (fifoCount)
  );

  always #5 clk = ~clk;

  entry_t        modelQ[$];
  logic          expRw;
  logic [AW-1:0] expWa;
  logic [DW-1:0] expWd;
  logic [DW-1:0] dutRf [2**AW];
  int            nAssert = 0;
  int            nFail = 0;
  int            dutWrites = 0;
  bit            lastAf = 1'b0;
  bit            lastMf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2**AW-1:0] modelPend();
    logic [2**AW-1:0] m = '0;
    foreach (modelQ[i]) m[modelQ[i].addr] = 1'b1;
    return m;
  endfunction

  // One clock: check handshake outputs with inputs settled, then the registered result.
  task automatic step();
    logic [2**AW-1:0] pm;
    bit ar, mr, af, mf, pp;
    entry_t aluIn, memIn;
    #1;
    pm = modelPend();
    ar = !pm[bus.alu_addr];
    mr = (modelQ.size() < DEPTH) && !flush;
    chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
    chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
    chk("pend_mask_pre", 32'(pendMask), 32'(pm));
    chk("fifo_count_pre", 32'(fifoCount), modelQ.size());
    af = bus.alu_valid && ar;
    mf = bus.mem_valid && mr;
    pp = !af && (modelQ.size() > 0) && !flush;
    aluIn = '{addr: bus.alu_addr, data: bus.alu_data};
    memIn = '{addr: bus.mem_addr, data: bus.mem_data};
    @(posedge clk);
    #1;
    if (af) begin
      expRw = 1'b1; expWa = aluIn.addr; expWd = aluIn.data;
    end else if (pp) begin
      expRw = 1'b1; expWa = modelQ[0].addr; expWd = modelQ[0].data;
    end else begin
      expRw = 1'b0;
    end
    if (flush) modelQ.delete();
    else begin
      if (pp) void'(modelQ.pop_front());
      if (mf) modelQ.push_back(memIn);
    end
    lastAf = af;
    lastMf = mf;
    chk("regwrite", 32'(bus.regwrite), 32'(expRw));
    chk("wr_addr", 32'(bus.wr_addr), 32'(expWa));
    chk("wr_data", 32'(bus.wr_data), 32'(expWd));
    chk("fifo_count", 32'(fifoCount), modelQ.size());
    chk("pend_mask", 32'(pendMask), 32'(modelPend()));
    if (bus.regwrite === 1'b1) begin
      dutRf[bus.wr_addr] = bus.wr_data;
      dutWrites++;
    end
  endtask

  task automatic idleInputs();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    idleInputs();
    for (int i = 0; i < 20 && modelQ.size() > 0; i++) step();
    step();
    chk("drain_empty", 32'(fifoCount), 0);
  endtask

  // Keeps the ALU busy on register 0 so three memory results stay buffered.
  task automatic fill3();
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 3'd0; bus.alu_data = 8'($urandom);
      bus.mem_valid = 1'b1; bus.mem_addr = 3'(5 + i); bus.mem_data = 8'($urandom);
      step();
    end
    idleInputs();
  endtask

  initial begin
    int k, base;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    expRw = 1'b0; expWa = '0; expWd = '0;
    foreach (dutRf[i]) dutRf[i] = '0;

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset_regwrite", 32'(bus.regwrite), 0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 0);
    chk("reset_wr_data", 32'(bus.wr_data), 0);
    chk("reset_fifo_count", 32'(fifoCount), 0);
    chk("reset_pend_mask", 32'(pendMask), 0);
    @(negedge clk) rst_n = 1'b1;

    // Memory latency and in-order drain
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd5; bus.mem_data = 8'hA5; step();
    bus.mem_addr = 3'd6; bus.mem_data = 8'h66; step();
    bus.mem_addr = 3'd7; bus.mem_data = 8'h77; step();
    drain();
    chk("drain_pend_mask", 32'(pendMask), 0);
    chk("drain_reg7", 32'(dutRf[7]), 32'h77);

    // Full FIFO backpressure while the ALU keeps the write port busy
    k = 0;
    for (int c = 0; c < 8; c++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 3'(c % 2); bus.alu_data = 8'($urandom);
      bus.mem_valid = (k < 5); bus.mem_addr = 3'(k + 3); bus.mem_data = 8'(8'h50 + k);
      step();
      if (lastMf) k++;
    end
    chk("full_count", 32'(fifoCount), DEPTH);
    chk("full_mem_ready", 32'(bus.mem_ready), 0);
    bus.alu_valid = 1'b0;
    for (int c = 0; c < 20 && (k < 5 || modelQ.size() > 0); c++) begin
      bus.mem_valid = (k < 5); bus.mem_addr = 3'(k + 3); bus.mem_data = 8'(8'h50 + k);
      step();
      if (lastMf) k++;
    end
    chk("full_all_pushed", k, 5);
    drain();

    // Ordering hazard: ALU waits behind an older buffered write to the same register
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd2; bus.mem_data = 8'h11; step();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd2; bus.alu_data = 8'h22;
    #1;
    chk("hazard_stall", 32'(bus.alu_ready), 0);
    for (int c = 0; c < 10; c++) begin
      step();
      if (lastAf) break;
    end
    chk("hazard_alu_done", 32'(lastAf), 1);
    drain();
    chk("hazard_reg2", 32'(dutRf[2]), 32'h22);

    // Same-cycle ALU and memory results to one register
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd4; bus.alu_data = 8'h40;
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd4; bus.mem_data = 8'h44;
    step();
    idleInputs();
    step();
    chk("tie_second", 32'(bus.wr_data), 32'h44);
    drain();
    chk("tie_reg4", 32'(dutRf[4]), 32'h44);

    // Flush with three buffered entries and an ALU write in the same cycle
    fill3();
    chk("flush_pre_count", 32'(fifoCount), 3);
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd1; bus.alu_data = 8'h09;
    bus.mem_valid = 1'b1; bus.mem_addr = 3'd3; bus.mem_data = 8'h33;
    flush = 1'b1;
    step();
    chk("flush_alu_data", 32'(bus.wr_data), 32'h09);
    chk("flush_mem_rejected", 32'(lastMf), 0);
    idleInputs();
    base = dutWrites;
    repeat (4) step();
    chk("flush_no_writes", dutWrites - base, 0);

    // Asynchronous reset mid-run with buffered entries
    fill3();
    chk("rst_pre_count", 32'(fifoCount), 3);
    rst_n = 1'b0;
    #2;
    chk("rst_regwrite", 32'(bus.regwrite), 0);
    chk("rst_fifo_count", 32'(fifoCount), 0);
    chk("rst_pend_mask", 32'(pendMask), 0);
    modelQ.delete();
    expRw = 1'b0; expWa = '0; expWd = '0;
    @(negedge clk) rst_n = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 3'd3; bus.alu_data = 8'd12;
    step();
    chk("post_rst_wr_addr", 32'(bus.wr_addr), 3);
    chk("post_rst_wr_data", 32'(bus.wr_data), 12);
    idleInputs();
    step();

    // Random traffic with held-until-accepted producers and occasional flushes
    lastAf = 1'b0;
    lastMf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(bus.alu_valid && !lastAf)) begin
        bus.alu_valid = ($urandom_range(0, 9) < 4);
        bus.alu_addr  = 3'($urandom_range(0, 7));
        bus.alu_data  = 8'($urandom);
      end
      if (!(bus.mem_valid && !lastMf)) begin
        bus.mem_valid = ($urandom_range(0, 9) < 6);
        bus.mem_addr  = 3'($urandom_range(0, 7));
        bus.mem_data  = 8'($urandom);
      end
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
